// File: rtl/bus_target_memory.sv
// rtl/bus_target_memory.sv - word memory responding to burst bus reads/writes, with a debug read port
module bus_target_memory #(
  parameter logic [31:0] Base  = 32'h40000000,
  parameter int          Depth = 512
) (
  input  logic        clock,
  input  logic        n_reset,
  input  logic [31:0] address_dataIN,
  input  logic        begin_transactionIN,
  input  logic        end_transactionIN,
  input  logic        data_validIN,
  input  logic        busyIN,
  input  logic        read_n_writeIN,
  input  logic [3:0]  byte_enableIN,
  input  logic [7:0]  burst_sizeIN,
  output logic [31:0] address_dataOUT,
  output logic        data_validOUT,
  output logic        end_transactionOUT,
  output logic        busyOUT,
  output logic        bus_errorOUT,
  input  logic [8:0]  local_address,
  output logic [31:0] local_dataOut
);

  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [32:0] WinLo  = {1'b0, Base};
  localparam logic [32:0] WinHi  = {1'b0, Base} + 33'(4 * Depth);
  localparam logic [AW:0] IdxOne = 1;

  typedef enum logic [2:0] {
    IDLE, RD_FETCH, RD_DATA, RD_END, WR_DATA, ERR_RD, ERR_WR
  } state_t;

  state_t state, state_n;

  logic [31:0] mem [Depth];

  // One extra index bit so the pointer can step past the last word without wrapping.
  logic [AW:0] idx;
  logic [AW:0] idx_inc;
  logic [8:0]  cnt;
  logic [3:0]  be;

  logic [31:0] offset, off_words;
  logic        selected, overrun;
  logic        load, advance, wr_en;
  logic        dv_n, end_n, err_n;
  logic [31:0] dout_n;

  assign offset    = address_dataIN - Base;
  assign off_words = offset >> 2;
  assign selected  = begin_transactionIN
                     && ({1'b0, address_dataIN} >= WinLo)
                     && ({1'b0, address_dataIN} <  WinHi);
  assign overrun   = (off_words + 32'(burst_sizeIN) + 32'd1) > 32'(Depth);
  assign idx_inc   = idx + IdxOne;
  assign busyOUT   = 1'b0;

  // Next state plus the next value of every registered bus output.
  always_comb begin
    state_n = state;
    dv_n    = 1'b0;
    end_n   = 1'b0;
    err_n   = 1'b0;
    dout_n  = '0;
    load    = 1'b0;
    advance = 1'b0;
    wr_en   = 1'b0;
    case (state)
      IDLE: begin
        if (selected) begin
          load = 1'b1;
          if (overrun) begin
            err_n   = 1'b1;
            state_n = read_n_writeIN ? ERR_RD : ERR_WR;
          end else begin
            state_n = read_n_writeIN ? RD_FETCH : WR_DATA;
          end
        end
      end
      RD_FETCH: begin
        if (end_transactionIN) begin
          state_n = IDLE;
        end else begin
          state_n = RD_DATA;
          dv_n    = 1'b1;
          dout_n  = mem[idx[AW-1:0]];
        end
      end
      RD_DATA: begin
        if (end_transactionIN) begin
          state_n = IDLE;
        end else if (busyIN) begin
          dv_n   = 1'b1;
          dout_n = address_dataOUT;
        end else begin
          advance = 1'b1;
          if (cnt == 9'd1) begin
            state_n = RD_END;
            end_n   = 1'b1;
          end else begin
            dv_n   = 1'b1;
            dout_n = mem[idx_inc[AW-1:0]];
          end
        end
      end
      RD_END: state_n = IDLE;
      WR_DATA: begin
        if (data_validIN && (cnt != 9'd0)) begin
          wr_en   = 1'b1;
          advance = 1'b1;
        end
        if (end_transactionIN) state_n = IDLE;
      end
      ERR_RD: begin
        state_n = RD_END;
        end_n   = 1'b1;
      end
      ERR_WR: begin
        if (end_transactionIN) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register and registered bus outputs.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state              <= IDLE;
      data_validOUT      <= 1'b0;
      end_transactionOUT <= 1'b0;
      bus_errorOUT       <= 1'b0;
      address_dataOUT    <= '0;
    end else begin
      state              <= state_n;
      data_validOUT      <= dv_n;
      end_transactionOUT <= end_n;
      bus_errorOUT       <= err_n;
      address_dataOUT    <= dout_n;
    end
  end

  // Burst bookkeeping: word pointer, remaining count and byte lanes.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      idx <= '0;
      cnt <= '0;
      be  <= '0;
    end else if (load) begin
      idx <= off_words[AW:0];
      cnt <= {1'b0, burst_sizeIN} + 9'd1;
      be  <= byte_enableIN;
    end else if (advance) begin
      idx <= idx_inc;
      cnt <= cnt - 9'd1;
    end
  end

  // Byte-lane write into the array; contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx[AW-1:0]][8*b +: 8] <= address_dataIN[8*b +: 8];
      end
    end
  end

  // Independent debug read port, one cycle of latency.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) local_dataOut <= '0;
    else          local_dataOut <= mem[local_address[AW-1:0]];
  end

endmodule

// File: tb/tb_bus_target_memory.sv
// tb/tb_bus_target_memory.sv - scoreboard bench for bus_target_memory
module tb_bus_target_memory;

  localparam logic [31:0] BASE = 32'h40000000;

  logic        clock = 1'b0;
  logic        n_reset;
  logic [31:0] address_dataIN;
  logic        begin_transactionIN, end_transactionIN, data_validIN, busyIN, read_n_writeIN;
  logic [3:0]  byte_enableIN;
  logic [7:0]  burst_sizeIN;
  logic [31:0] address_dataOUT;
  logic        data_validOUT, end_transactionOUT, busyOUT, bus_errorOUT;
  logic [8:0]  local_address;
  logic [31:0] local_dataOut;

  bus_target_memory #(.Base(BASE), .Depth(512)) dut (
    .clock              (clock),
    .n_reset            (n_reset),
    .address_dataIN     (address_dataIN),
    .begin_transactionIN(begin_transactionIN),
    .end_transactionIN  (end_transactionIN),
    .data_validIN       (data_validIN),
    .busyIN             (busyIN),
    .read_n_writeIN     (read_n_writeIN),
    .byte_enableIN      (byte_enableIN),
    .burst_sizeIN       (burst_sizeIN),
    .address_dataOUT    (address_dataOUT),
    .data_validOUT      (data_validOUT),
    .end_transactionOUT (end_transactionOUT),
    .busyOUT            (busyOUT),
    .bus_errorOUT       (bus_errorOUT),
    .local_address      (local_address),
    .local_dataOut      (local_dataOut)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    int          cyc;
    logic        dv;
    logic        en;
    logic        er;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  ev_t e;
  int  n_checks = 0;
  int  n_pass   = 0;

  // Monitor: any visible bus activity must match the head of the expected queue.
  always @(negedge clock) begin
    if (data_validOUT || end_transactionOUT || bus_errorOUT || busyOUT || (address_dataOUT != 0)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_bus_output cyc=%0d dv=%b end=%b err=%b busy=%b data=%h required idle",
                 cyc, data_validOUT, end_transactionOUT, bus_errorOUT, busyOUT, address_dataOUT);
      end else begin
        e = exp_q.pop_front();
        if (cyc == e.cyc && data_validOUT === e.dv && end_transactionOUT === e.en &&
            bus_errorOUT === e.er && busyOUT === 1'b0 && address_dataOUT === e.data)
          n_pass++;
        else
          $display("FAIL bus_event actual cyc=%0d dv=%b end=%b err=%b busy=%b data=%h required cyc=%0d dv=%b end=%b err=%b busy=0 data=%h",
                   cyc, data_validOUT, end_transactionOUT, bus_errorOUT, busyOUT, address_dataOUT,
                   e.cyc, e.dv, e.en, e.er, e.data);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ev(input int c, input logic dv, input logic en, input logic er, input logic [31:0] d);
    ev_t x;
    x.cyc = c; x.dv = dv; x.en = en; x.er = er; x.data = d;
    exp_q.push_back(x);
  endtask

  task automatic start(input logic [31:0] addr, input logic [7:0] burst, input logic [3:0] be, input logic rnw);
    address_dataIN      = addr;
    burst_sizeIN        = burst;
    byte_enableIN       = be;
    read_n_writeIN      = rnw;
    begin_transactionIN = 1'b1;
    tick();
    begin_transactionIN = 1'b0;
    address_dataIN      = '0;
    burst_sizeIN        = '0;
    byte_enableIN       = '0;
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [7:0] burst, input logic [3:0] be,
                             input logic [31:0] wq[$]);
    start(addr, burst, be, 1'b0);
    foreach (wq[i]) begin
      address_dataIN = wq[i];
      data_validIN   = 1'b1;
      tick();
    end
    data_validIN      = 1'b0;
    address_dataIN    = '0;
    end_transactionIN = 1'b1;
    tick();
    end_transactionIN = 1'b0;
  endtask

  task automatic run_read(input logic [31:0] addr, input logic [7:0] burst, input logic [15:0] busy_mask,
                          input int abort_at, input int ncyc);
    start(addr, burst, 4'hF, 1'b1);
    for (int k = 1; k <= ncyc; k++) begin
      busyIN            = busy_mask[k];
      end_transactionIN = (k == abort_at);
      tick();
    end
    busyIN            = 1'b0;
    end_transactionIN = 1'b0;
  endtask

  task automatic local_check(input logic [8:0] a, input logic [31:0] req, input string name);
    local_address = a;
    tick();
    check(name, local_dataOut, req);
  endtask

  initial begin
    int c0;
    logic [31:0] wq[$];
    n_reset = 1'b0;
    address_dataIN = '0; begin_transactionIN = 0; end_transactionIN = 0; data_validIN = 0;
    busyIN = 0; read_n_writeIN = 0; byte_enableIN = '0; burst_sizeIN = '0; local_address = '0;
    repeat (3) tick();
    check("reset_ctrl", {28'd0, data_validOUT, end_transactionOUT, bus_errorOUT, busyOUT}, 32'd0);
    check("reset_data", address_dataOUT, 32'd0);
    check("reset_local", local_dataOut, 32'd0);
    n_reset = 1'b1;
    tick();

    wq = {32'h11, 32'h22, 32'h33, 32'h44};
    write_burst(BASE + 8, 8'd3, 4'hF, wq);
    local_check(9'd2, 32'h11, "wr_word2");
    local_check(9'd3, 32'h22, "wr_word3");
    local_check(9'd4, 32'h33, "wr_word4");
    local_check(9'd5, 32'h44, "wr_word5");

    c0 = cyc;
    ev(c0 + 2, 1, 0, 0, 32'h11); ev(c0 + 3, 1, 0, 0, 32'h22); ev(c0 + 4, 1, 0, 0, 32'h22);
    ev(c0 + 5, 1, 0, 0, 32'h22); ev(c0 + 6, 1, 0, 0, 32'h33); ev(c0 + 7, 1, 0, 0, 32'h44);
    ev(c0 + 8, 0, 1, 0, 32'h0);
    run_read(BASE + 8, 8'd3, 16'h0018, -1, 10);

    wq = {32'hAABBCCDD};
    write_burst(BASE + 8, 8'd0, 4'b0011, wq);
    local_check(9'd2, 32'h0000CCDD, "be_word2");
    local_check(9'd3, 32'h22, "be_word3_untouched");

    wq = {32'h55, 32'h66};
    write_burst(BASE + 16, 8'd0, 4'hF, wq);
    local_check(9'd4, 32'h55, "extra_word4");
    local_check(9'd5, 32'h44, "extra_discarded");

    wq = {32'hDEAD0510, 32'hDEAD0511};
    write_burst(BASE + 4 * 510, 8'd1, 4'hF, wq);
    local_check(9'd510, 32'hDEAD0510, "top_word510");
    local_check(9'd511, 32'hDEAD0511, "top_word511");
    c0 = cyc;
    ev(c0 + 2, 1, 0, 0, 32'hDEAD0510); ev(c0 + 3, 1, 0, 0, 32'hDEAD0511); ev(c0 + 4, 0, 1, 0, 32'h0);
    run_read(BASE + 4 * 510, 8'd1, 16'h0, -1, 6);

    c0 = cyc;
    ev(c0 + 1, 0, 0, 1, 32'h0); ev(c0 + 2, 0, 1, 0, 32'h0);
    run_read(BASE + 4 * 510, 8'd3, 16'h0, -1, 5);
    c0 = cyc;
    ev(c0 + 1, 0, 0, 1, 32'h0);
    wq = {32'h1, 32'h2, 32'h3, 32'h4};
    write_burst(BASE + 4 * 510, 8'd3, 4'hF, wq);
    local_check(9'd510, 32'hDEAD0510, "ovr_word510_kept");
    local_check(9'd511, 32'hDEAD0511, "ovr_word511_kept");

    c0 = cyc;
    ev(c0 + 2, 1, 0, 0, 32'h0000CCDD); ev(c0 + 3, 1, 0, 0, 32'h22);
    run_read(BASE + 8, 8'd3, 16'h0, 3, 6);

    start(BASE - 4, 8'd0, 4'hF, 1'b1);
    check("foreign_lo_idle", {data_validOUT, end_transactionOUT, bus_errorOUT, busyOUT} | address_dataOUT, 32'd0);
    start(BASE + 2048, 8'd0, 4'hF, 1'b0);
    check("foreign_hi_idle", {data_validOUT, end_transactionOUT, bus_errorOUT, busyOUT} | address_dataOUT, 32'd0);
    c0 = cyc;
    ev(c0 + 2, 1, 0, 0, 32'h55); ev(c0 + 3, 0, 1, 0, 32'h0);
    run_read(BASE + 16, 8'd0, 16'h0, -1, 5);

    c0 = cyc;
    ev(c0 + 2, 1, 0, 0, 32'h0000CCDD); ev(c0 + 3, 1, 0, 0, 32'h22);
    start(BASE + 8, 8'd7, 4'hF, 1'b1);
    repeat (3) tick();
    n_reset = 1'b0;
    #1;
    check("midreset_ctrl", {28'd0, data_validOUT, end_transactionOUT, bus_errorOUT, busyOUT}, 32'd0);
    check("midreset_data", address_dataOUT, 32'd0);
    check("midreset_local", local_dataOut, 32'd0);
    repeat (2) tick();
    n_reset = 1'b1;
    tick();
    local_check(9'd2, 32'h0000CCDD, "mem_kept_over_reset");
    c0 = cyc;
    ev(c0 + 2, 1, 0, 0, 32'h55); ev(c0 + 3, 1, 0, 0, 32'h44); ev(c0 + 4, 0, 1, 0, 32'h0);
    run_read(BASE + 16, 8'd1, 16'h0, -1, 6);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("events_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_target_memory.md
BUS_TARGET_MEMORY -- requirements
Module: bus_target_memory

Interface
REQ-001 SHALL have parameter Base, default 32'h40000000, meaning the byte address of word 0 of the window.
REQ-002 SHALL have parameter Depth, default 512, meaning the number of 32-bit words (power of two, max 512).
REQ-003 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port n_reset, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port address_dataIN, input, 32 bits: address on the begin cycle, write data otherwise.
REQ-006 Port begin_transactionIN, end_transactionIN, data_validIN, busyIN, read_n_writeIN, inputs, 1 bit each: bus control from the initiator.
REQ-007 Port byte_enableIN, input, 4 bits, and burst_sizeIN, input, 8 bits: sampled on the begin cycle only. The burst length is burst_sizeIN+1 words.
REQ-008 Port address_dataOUT, output, 32 bits: read data.
REQ-009 Ports data_validOUT, end_transactionOUT, busyOUT, bus_errorOUT, outputs, 1 bit each: responder-driven bus control.
REQ-010 Ports local_address (input, 9 bits) and local_dataOut (output, 32 bits): an independent read port with 1-cycle latency, for debug and verification.

Function
REQ-011 All bus outputs SHALL be registered. When the block is not driving a response, they SHALL read as 0.
REQ-012 The block SHALL be selected when begin_transactionIN=1 and Base <= address_dataIN < Base+4*Depth. Otherwise it SHALL ignore the transaction and stay in IDLE. Address bits [1:0] are ignored.
REQ-013 FSM states: IDLE, RD_FETCH, RD_DATA, RD_END, WR_DATA, ERR_RD, ERR_WR.
REQ-014 On a selected begin, the block SHALL latch the word index, byte enable, remaining count (burst_sizeIN+1, 9 bits, 256 max) and direction.
REQ-015 Overrun check at begin: if word_index + burst_sizeIN + 1 > Depth, the block SHALL enter ERR_RD or ERR_WR.
REQ-016 Reads: IDLE -> RD_FETCH (memory read issued) -> RD_DATA.
REQ-017 In RD_DATA the block SHALL drive data_validOUT=1 with mem[index], advancing index and decrementing remaining count each cycle that busyIN=0.
REQ-018 While busyIN=1 in RD_DATA, the block SHALL hold address_dataOUT and data_validOUT unchanged, with no advance.
REQ-019 First read data SHALL appear on address_dataOUT 2 cycles after the begin cycle, given busyIN=0.
REQ-020 After the last word is accepted, the block SHALL go to RD_END, which drives end_transactionOUT=1 for exactly one cycle, then IDLE.
REQ-021 end_transactionIN=1 during RD_FETCH or RD_DATA (an initiator abort) SHALL return the block to IDLE next cycle with data_validOUT=0 and no end_transactionOUT.
REQ-022 Writes: IDLE -> WR_DATA. Each cycle with data_validIN=1, the block SHALL write address_dataIN to mem[index] with only the byte lanes in the latched byte enable updated, then advance index and decrement the count.
REQ-023 Words arriving after the count reaches 0 SHALL be discarded.
REQ-024 WR_DATA SHALL exit to IDLE on end_transactionIN=1. A data word in that same cycle is still written if the count is nonzero.
REQ-025 busyOUT SHALL be constantly 0; the responder never stalls.
REQ-026 ERR_RD SHALL drive bus_errorOUT=1 for one cycle, then end_transactionOUT=1 for one cycle, then go to IDLE. No memory access occurs.
REQ-027 ERR_WR SHALL drive bus_errorOUT=1 for one cycle, then ignore data until end_transactionIN=1, then go to IDLE. No memory write occurs.
REQ-028 begin_transactionIN outside IDLE SHALL be ignored.
REQ-029 The word index SHALL never wrap; the overrun check guarantees this.

Reset
REQ-030 While n_reset=0, the block SHALL force: FSM to IDLE, all bus outputs and counters to 0, and local_dataOut to 0. This applies immediately, asynchronously, including mid-burst.
REQ-031 Memory contents are undefined after power-up and are not cleared by reset. A burst interrupted by reset SHALL leave already-written words intact.

Verification
REQ-032 Write burst: address=Base+8, burst 3, byte enable F, data 11,22,33,44, then end -> local reads of words 2..5 return 11,22,33,44; busyOUT is 0 throughout.
REQ-033 Read burst of the same 4 words with busyIN=1 for 2 cycles after the 2nd word -> data 11,22,22,22,33,44 (the 22 held while stalled); end_transactionOUT pulses once, 1 cycle after 44.
REQ-034 Byte-enable write: byte enable 4'b0011, data AABBCCDD to word 2 (old value 00000011) -> word 2 reads 0000CCDD.
REQ-035 Overrun: read at Base+4*510, burst 3 -> bus_errorOUT=1 one cycle, end_transactionOUT=1 the next, no data_validOUT. A write with the same parameters leaves words 510..511 unchanged.
REQ-036 Foreign address: begin at Base-4 or Base+2048 -> all outputs stay 0 and the FSM stays IDLE.
REQ-037 Reset mid-read after 2 of 8 words -> outputs are 0 within the reset assertion, and a subsequent read burst operates normally.
